calbus_arbiter: RTL
===================

CALBUS_ARBITER -- requirements
Module: calbus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports (2..8).
REQ-002 Parameter RD_LATENCY, default 2: calbus cycles from read pulse to valid calbus_rdata (1..15).
REQ-003 Parameter ADDR_W, default 20: calbus address width.
REQ-004 Parameter DATA_W, default 32: calbus data width.
REQ-005 calbus_clk  in  1: single clock; all logic on rising edge.
REQ-006 calbus_reset  in  1: asynchronous, active-high reset.
REQ-007 req_read  in  NUM_REQ: per-requester read request, held until accepted.
REQ-008 req_write  in  NUM_REQ: per-requester write request, held until accepted.
REQ-009 req_address  in  NUM_REQ*ADDR_W: packed per-requester addresses, requester i at slice i.
REQ-010 req_wdata  in  NUM_REQ*DATA_W: packed per-requester write data.
REQ-011 req_waitrequest  out  NUM_REQ: high = command not yet accepted.
REQ-012 req_rdata  out  DATA_W: read data shared by all requesters, qualified by req_rdata_valid.
REQ-013 req_rdata_valid  out  NUM_REQ: one-cycle read-return strobe for the owning requester.
REQ-014 calbus_read  out  1: one-cycle read command to IOSSM calbus.
REQ-015 calbus_write  out  1: one-cycle write command to IOSSM calbus.
REQ-016 calbus_address  out  ADDR_W: calbus address, valid with command pulse.
REQ-017 calbus_wdata  out  DATA_W: calbus write data, valid with calbus_write.
REQ-018 calbus_rdata  in  DATA_W: calbus read data, valid RD_LATENCY cycles after calbus_read.
REQ-019 grant_id  out  clog2(NUM_REQ): index of current/last granted requester.
REQ-020 busy  out  1: high whenever state is not IDLE.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT_RD, RESP; IDLE -> ISSUE when any bit of (req_read|req_write) is set, else stay.
REQ-022 In IDLE, round-robin grant: search starts at (last_grant+1) mod NUM_REQ, first requester with read or write set wins; grant, command type, address, wdata registered at the same edge.
REQ-023 In ISSUE (exactly one cycle): drive calbus_read or calbus_write high from registered copy; req_waitrequest[grant] low this cycle only; last_grant updated to grant.
REQ-024 req_waitrequest bits SHALL be high in every other cycle and for every non-granted requester.
REQ-025 ISSUE -> IDLE after a write; ISSUE -> WAIT_RD after a read.
REQ-026 WAIT_RD counts RD_LATENCY-1 further cycles; at the edge ending cycle ISSUE+RD_LATENCY, capture calbus_rdata into req_rdata and go to RESP.
REQ-027 In RESP (one cycle): req_rdata_valid[grant] high, all other bits low; RESP -> IDLE; req_rdata holds value until next capture.
REQ-028 Latency: request seen in IDLE at cycle T -> command on calbus at T+1; read data strobe at T+2+RD_LATENCY; write-to-write back-to-back throughput one command per 2 cycles.
REQ-029 Requester asserting read and write together: write issued, read discarded, single acceptance.
REQ-030 Command fields are taken from the IDLE-cycle capture; requester changes before acceptance do not alter the issued command.
REQ-031 calbus_address/calbus_wdata SHALL be zero whenever no command pulse is driven.
REQ-032 Only one outstanding calbus transaction at any time; no new grant before return to IDLE.

Reset
REQ-033 calbus_reset high: state IDLE, calbus_read/write 0, calbus_address/wdata 0, req_waitrequest all 1, req_rdata_valid 0, req_rdata 0, busy 0, grant_id 0, last_grant NUM_REQ-1 (requester 0 wins first).
REQ-034 Reset asserted mid-read aborts transaction; no req_rdata_valid issued for it after release.

Verification
REQ-035 Single read: req 1 reads addr 0x00420, calbus_rdata=0xDEADBEEF at ISSUE+2 -> calbus_read at T+1, req_waitrequest[1] low at T+1, req_rdata_valid[1] at T+4 with 0xDEADBEEF.
REQ-036 All 4 requesters write simultaneously after reset -> grants in order 0,1,2,3, one calbus_write every 2 cycles, correct address/wdata each.
REQ-037 Round-robin fairness: req 0 and 2 continuously request after grant 2 -> next grants 0,2,0,2.
REQ-038 Simultaneous read+write on req 3 -> one calbus_write, no calbus_read, no rdata_valid.
REQ-039 Reset pulse during WAIT_RD -> all outputs at reset values next cycle, no stray rdata_valid, first post-reset grant to requester 0.
REQ-040 RD_LATENCY=1 and =15 builds -> rdata_valid at T+3 and T+17 respectively.

Source files
------------

// File: rtl/calbus_arbiter_if.sv
// rtl/calbus_arbiter_if.sv - requester and calbus signal bundle for calbus_arbiter
// Purpose: carries the per-requester command/response signals and the IOSSM
//          calbus signals between the arbiter and its environment.
// Signals:
//   req_read/req_write  [NUM_REQ]          per-requester commands, held until accepted
//   req_address/wdata   [NUM_REQ*W]        packed per-requester fields, requester i at slice i
//   req_waitrequest     [NUM_REQ]          low only in the acceptance cycle of the granted requester
//   req_rdata           [DATA_W]           shared read return data
//   req_rdata_valid     [NUM_REQ]          one-cycle read return strobe
//   calbus_read/write                      one-cycle command pulses
//   calbus_address/wdata                   command fields, zero outside a pulse
//   calbus_rdata        [DATA_W]           read data from the calbus
//   grant_id            [clog2(NUM_REQ)]   current/last granted requester
//   busy                                   arbiter not idle
// Modports: master = arbiter side, slave = requesters plus calbus side.
interface calbus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int GRANT_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_rdata_valid;
  logic                      calbus_read;
  logic                      calbus_write;
  logic [ADDR_W-1:0]         calbus_address;
  logic [DATA_W-1:0]         calbus_wdata;
  logic [DATA_W-1:0]         calbus_rdata;
  logic [GRANT_W-1:0]        grant_id;
  logic                      busy;

  modport master (
    input  req_read, req_write, req_address, req_wdata, calbus_rdata,
    output req_waitrequest, req_rdata, req_rdata_valid, calbus_read, calbus_write,
           calbus_address, calbus_wdata, grant_id, busy
  );

  modport slave (
    output req_read, req_write, req_address, req_wdata, calbus_rdata,
    input  req_waitrequest, req_rdata, req_rdata_valid, calbus_read, calbus_write,
           calbus_address, calbus_wdata, grant_id, busy
  );
endinterface

// File: rtl/calbus_arbiter.sv
// rtl/calbus_arbiter.sv - round-robin arbiter of NUM_REQ requesters onto one IOSSM calbus
// Purpose: grants one requester at a time, issues its read or write as a
//          one-cycle calbus pulse, and for reads returns the data RD_LATENCY
//          cycles later with a one-cycle strobe to the owning requester.
// Ports:
//   calbus_clk    clock, rising edge
//   calbus_reset  asynchronous active-high reset
//   bus           calbus_arbiter_if.master (requester side and calbus side)
module calbus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32
) (
  input  logic             calbus_clk,
  input  logic             calbus_reset,
  calbus_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_last_grant;
  logic [GW-1:0]      w_pick;
  logic [GW-1:0]      w_idx;
  logic               w_found;
  logic               r_is_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [3:0]         r_cnt;
  logic [NUM_REQ-1:0] w_req;
  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

  assign w_req = bus.req_read | bus.req_write;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = bus.req_address[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin: scan from the requester after the last grant, wrapping,
  // so the last granted requester is considered last.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = GW'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_found && w_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge calbus_clk or posedge calbus_reset) begin
    if (calbus_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next_state = S_ISSUE;
      S_ISSUE:   w_next_state = r_is_write ? S_IDLE : S_WAIT_RD;
      S_WAIT_RD: if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Command fields are frozen at the grant edge; later requester changes
  // cannot reach the calbus. Write wins when read and write are both set.
  always_ff @(posedge calbus_clk or posedge calbus_reset) begin
    if (calbus_reset) begin
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_pick;
            r_is_write <= bus.req_write[w_pick];
            r_addr     <= w_addr_arr[w_pick];
            r_wdata    <= w_wdata_arr[w_pick];
          end
        end
        S_ISSUE: begin
          r_last_grant <= r_grant;
          // First WAIT_RD cycle is ISSUE+1; data is valid in cycle ISSUE+RD_LATENCY.
          r_cnt        <= 4'(RD_LATENCY - 1);
        end
        S_WAIT_RD: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= bus.calbus_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_waitrequest = '1;
    bus.req_rdata_valid = '0;
    bus.calbus_read     = 1'b0;
    bus.calbus_write    = 1'b0;
    bus.calbus_address  = '0;
    bus.calbus_wdata    = '0;
    case (r_state)
      S_ISSUE: begin
        bus.req_waitrequest[r_grant] = 1'b0;
        bus.calbus_read              = !r_is_write;
        bus.calbus_write             = r_is_write;
        bus.calbus_address           = r_addr;
        if (r_is_write) bus.calbus_wdata = r_wdata;
      end
      S_RESP: bus.req_rdata_valid[r_grant] = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_rdata = r_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.grant_id  = r_grant;
endmodule
